// File: rtl/riscv_exec_control_if.sv
// ---------------------------------------------------------------------------
// riscv_exec_control_if
//
// Signal bundle between the execution-control core and its neighbours
// (decoder / register file on one side, instruction / data memory units on
// the other).  Widths are fixed by the RV32I datapath.
//
//   slave  modport : the execution-control core itself
//   master modport : whoever drives decoded fields and consumes the results
//
// Members
//   stall                  bus not ready (instruction or data side)
//   opcode, f3, f7         decoded instruction fields
//   rs1_data, rs2_data     register operands
//   imm                    sign-extended immediate
//   insn_len               instruction length in bytes
//   current_pc             address of the executing instruction
//   mem_rdata              load data from the memory unit
//   alu_out                ALU result, also the data address
//   rd_data, rd_we         write-back value and strobe
//   dbus_re, dbus_we       data bus strobes
//   fetch_next_instruction request an instruction fetch
//   load_ir                capture the fetched instruction
//   write_back_stage       core is in WRITEBACK
//   next_pc                program counter
//   illegal                opcode unsupported
// ---------------------------------------------------------------------------
interface riscv_exec_control_if;
    logic        stall;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] insn_len;
    logic [31:0] current_pc;
    logic [31:0] mem_rdata;
    logic [31:0] alu_out;
    logic [31:0] rd_data;
    logic        rd_we;
    logic        dbus_re;
    logic        dbus_we;
    logic        fetch_next_instruction;
    logic        load_ir;
    logic        write_back_stage;
    logic [31:0] next_pc;
    logic        illegal;

    modport slave (
        input  stall, opcode, f3, f7, rs1_data, rs2_data, imm, insn_len,
               current_pc, mem_rdata,
        output alu_out, rd_data, rd_we, dbus_re, dbus_we,
               fetch_next_instruction, load_ir, write_back_stage, next_pc,
               illegal
    );

    modport master (
        output stall, opcode, f3, f7, rs1_data, rs2_data, imm, insn_len,
               current_pc, mem_rdata,
        input  alu_out, rd_data, rd_we, dbus_re, dbus_we,
               fetch_next_instruction, load_ir, write_back_stage, next_pc,
               illegal
    );
endinterface

// File: rtl/riscv_exec_control.sv
// ---------------------------------------------------------------------------
// riscv_exec_control
//
// Execution-control core of the multi-cycle RV32I CPU: control FSM
// (FETCH -> EXECUTE -> WRITEBACK), ALU with operand muxes, and the program
// counter with branch stepping.
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   riscv_exec_control_if.slave (decoded fields in, results out)
//
// Parameters
//   RESET_PC  value loaded into next_pc on reset
//
// Optional build macro
//   EXEC_TRACE_EN  when defined, every state transition prints time, state,
//                  opcode, ALU mode, alu_out and next_pc.  Behaviour is
//                  otherwise identical.
// ---------------------------------------------------------------------------
module riscv_exec_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_exec_control_if.slave  bus
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {FETCH, EXECUTE, WRITEBACK} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_mode_t;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
    typedef enum logic       {B_RS2, B_IMM} b_sel_t;
    typedef enum logic [1:0] {RD_NONE, RD_ALU, RD_LINK, RD_MEM} rd_src_t;
    typedef enum logic [1:0] {PC_STEP, PC_JAL, PC_JALR} pc_op_t;

    // f3 -> ALU mode for OP / OP-IMM.  'alt' is f7[5]; SUB only exists in
    // the register form because OP-IMM reuses those bits as immediate.
    function automatic alu_mode_t arith_mode(input logic [2:0] f3,
                                             input logic       alt,
                                             input logic       reg_form);
        alu_mode_t m;
        case (f3)
            3'b000:  m = (alt && reg_form) ? ALU_SUB : ALU_ADD;
            3'b001:  m = ALU_SLL;
            3'b010:  m = ALU_SLT;
            3'b011:  m = ALU_SLTU;
            3'b100:  m = ALU_XOR;
            3'b101:  m = alt ? ALU_SRA : ALU_SRL;
            3'b110:  m = ALU_OR;
            default: m = ALU_AND;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] alu_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input alu_mode_t   mode);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         sh;
        logic [31:0]        r;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (mode)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << sh;
            ALU_SLT:  r = {31'd0, (sa < sb)};
            ALU_SLTU: r = {31'd0, (a < b)};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = sa >>> sh;
            ALU_OR:   r = a | b;
            default:  r = a & b;
        endcase
        return r;
    endfunction

    state_t      state_q;
    logic        fetch_q;
    logic        exec_q;
    logic        wb_q;
    logic [31:0] pc_q;

    a_sel_t      a_sel;
    b_sel_t      b_sel;
    alu_mode_t   alu_mode;
    rd_src_t     rd_src;
    pc_op_t      pc_op;
    logic        invert;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        unsupported;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] link;
    logic        take;
    logic [31:0] step;
    logic [31:0] pc_target;
    logic        advance;
    logic        wb_exit;

    // Only f7[5] carries meaning for RV32I; the rest is decoder residue.
    logic        unused_f7;
    assign unused_f7 = ^{bus.f7[6], bus.f7[4:0]};

    // Decode: operand selects, ALU mode, write-back source, PC action.
    always_comb begin
        a_sel       = A_RS1;
        b_sel       = B_IMM;
        alu_mode    = ALU_ADD;
        rd_src      = RD_NONE;
        pc_op       = PC_STEP;
        invert      = 1'b0;
        is_branch   = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        unsupported = 1'b0;
        case (bus.opcode)
            OP_LUI: begin
                a_sel  = A_ZERO;
                rd_src = RD_ALU;
            end
            OP_AUIPC: begin
                a_sel  = A_PC;
                rd_src = RD_ALU;
            end
            OP_JAL: begin
                a_sel  = A_PC;
                rd_src = RD_LINK;
                pc_op  = PC_JAL;
            end
            OP_JALR: begin
                rd_src = RD_LINK;
                pc_op  = PC_JALR;
            end
            OP_BRANCH: begin
                b_sel     = B_RS2;
                is_branch = 1'b1;
                case (bus.f3)
                    3'b000: begin alu_mode = ALU_SUB;  invert = 1'b1; end
                    3'b001: begin alu_mode = ALU_SUB;  invert = 1'b0; end
                    3'b100: begin alu_mode = ALU_SLT;  invert = 1'b0; end
                    3'b101: begin alu_mode = ALU_SLT;  invert = 1'b1; end
                    3'b110: begin alu_mode = ALU_SLTU; invert = 1'b0; end
                    3'b111: begin alu_mode = ALU_SLTU; invert = 1'b1; end
                    default: begin alu_mode = ALU_SUB; invert = 1'b0; end
                endcase
            end
            OP_LOAD: begin
                is_load = 1'b1;
                rd_src  = RD_MEM;
            end
            OP_STORE: begin
                is_store = 1'b1;
            end
            OP_IMM: begin
                alu_mode = arith_mode(bus.f3, bus.f7[5], 1'b0);
                rd_src   = RD_ALU;
            end
            OP_REG: begin
                b_sel    = B_RS2;
                alu_mode = arith_mode(bus.f3, bus.f7[5], 1'b1);
                rd_src   = RD_ALU;
            end
            default: begin
                unsupported = 1'b1;
            end
        endcase
    end

    // Operand muxes and ALU.
    always_comb begin
        case (a_sel)
            A_PC:    op_a = bus.current_pc;
            A_ZERO:  op_a = 32'd0;
            default: op_a = bus.rs1_data;
        endcase
        op_b    = (b_sel == B_RS2) ? bus.rs2_data : bus.imm;
        alu_res = alu_calc(op_a, op_b, alu_mode);
    end

    assign link = bus.current_pc + bus.insn_len;
    assign take = (alu_res != 32'd0) ^ invert;
    assign step = (is_branch && take) ? bus.imm : bus.insn_len;

    always_comb begin
        case (pc_op)
            PC_JAL:  pc_target = alu_res;
            PC_JALR: pc_target = {alu_res[31:1], 1'b0};
            default: pc_target = pc_q + step;
        endcase
    end

    // Whether the current state is finished this cycle.
    always_comb begin
        case (state_q)
            FETCH:     advance = !bus.stall;
            EXECUTE:   advance = !((is_load || is_store) && bus.stall);
            WRITEBACK: advance = !bus.stall;
            default:   advance = 1'b1;
        endcase
    end

    assign wb_exit = wb_q && !bus.stall;

    // Control FSM; the one-hot flags are the registered state outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            fetch_q <= 1'b1;
            exec_q  <= 1'b0;
            wb_q    <= 1'b0;
        end else if (advance) begin
            case (state_q)
                FETCH: begin
                    state_q <= EXECUTE;
                    fetch_q <= 1'b0;
                    exec_q  <= 1'b1;
                    wb_q    <= 1'b0;
                end
                EXECUTE: begin
                    state_q <= WRITEBACK;
                    fetch_q <= 1'b0;
                    exec_q  <= 1'b0;
                    wb_q    <= 1'b1;
                end
                default: begin
                    state_q <= FETCH;
                    fetch_q <= 1'b1;
                    exec_q  <= 1'b0;
                    wb_q    <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: updated only on the WRITEBACK exit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (wb_exit) begin
            pc_q <= pc_target;
        end
    end

`ifdef EXEC_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && advance) begin
            $display("%0t exec_control: state=%s opcode=%b mode=%s alu_out=%h next_pc=%h",
                     $time, state_q.name(), bus.opcode, alu_mode.name(),
                     alu_res, pc_q);
        end
    end
`else
`endif

    // rd_we and the data strobes depend on the decoded instruction, which is
    // only valid once the IR has been captured, so they are qualified here.
    always_comb begin
        case (rd_src)
            RD_LINK: bus.rd_data = link;
            RD_MEM:  bus.rd_data = bus.mem_rdata;
            default: bus.rd_data = alu_res;
        endcase
    end

    assign bus.alu_out                = alu_res;
    assign bus.rd_we                  = wb_exit && (rd_src != RD_NONE);
    assign bus.dbus_re                = exec_q && is_load;
    assign bus.dbus_we                = exec_q && is_store;
    assign bus.fetch_next_instruction = fetch_q;
    assign bus.load_ir                = fetch_q;
    assign bus.write_back_stage       = wb_q;
    assign bus.next_pc                = pc_q;
    assign bus.illegal                = !fetch_q && unsupported;

endmodule

// File: tb/tb_riscv_exec_control.sv
// ---------------------------------------------------------------------------
// tb_riscv_exec_control
//
// Directed bench for riscv_exec_control: a table of single-instruction
// vectors with hand-computed results (next_pc tracked cumulatively through
// the table), followed by hand-written stall and mid-instruction reset
// sequences.
// ---------------------------------------------------------------------------
module tb_riscv_exec_control;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPREG  = 7'b0110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    typedef struct {
        string       nm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] cpc;
        logic [31:0] mrd;
        bit          chk_alu;
        logic [31:0] alu;
        logic        rd_we;
        logic [31:0] rd;
        logic        re;
        logic        we;
        logic        ill;
        logic [31:0] npc;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[25];

    riscv_exec_control_if bus();

    riscv_exec_control #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.opcode     = v.op;
        bus.f3         = v.f3;
        bus.f7         = v.f7;
        bus.rs1_data   = v.rs1;
        bus.rs2_data   = v.rs2;
        bus.imm        = v.imm;
        bus.current_pc = v.cpc;
        bus.mem_rdata  = v.mrd;
        bus.insn_len   = 32'd4;
    endtask

    // Entered and left at edge+1 in FETCH, stall low throughout.
    task automatic run_vec(input vec_t v);
        apply(v);
        bus.stall = 1'b0;
        #1;
        chk({v.nm, ".fetch"}, 32'(bus.fetch_next_instruction), 32'd1);
        step();
        if (v.chk_alu) chk({v.nm, ".alu"}, bus.alu_out, v.alu);
        chk({v.nm, ".ex_re"}, 32'(bus.dbus_re), 32'(v.re));
        chk({v.nm, ".ex_we"}, 32'(bus.dbus_we), 32'(v.we));
        chk({v.nm, ".ex_ill"}, 32'(bus.illegal), 32'(v.ill));
        chk({v.nm, ".ex_rdwe"}, 32'(bus.rd_we), 32'd0);
        step();
        chk({v.nm, ".wb_stage"}, 32'(bus.write_back_stage), 32'd1);
        chk({v.nm, ".wb_rdwe"}, 32'(bus.rd_we), 32'(v.rd_we));
        if (v.rd_we) chk({v.nm, ".rd_data"}, bus.rd_data, v.rd);
        step();
        chk({v.nm, ".next_pc"}, bus.next_pc, v.npc);
        chk({v.nm, ".rdwe_after"}, 32'(bus.rd_we), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //              nm        op      f3      f7      rs1           rs2           imm           cpc           mrd           ca alu           we rd            re we il npc
        vecs[0]  = '{"addi",   OPIMM,  3'b000, 7'h7F, 32'd5,        32'd0,        32'hFFFF_FFF9, 32'h0,       32'h0,        1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 0, 0, 0, 32'h4};
        vecs[1]  = '{"jal1",   JAL,    3'b000, 7'h00, 32'd0,        32'd0,        32'h0000_00FC, 32'h4,       32'h0,        1, 32'h100,       1, 32'h8,         0, 0, 0, 32'h100};
        vecs[2]  = '{"beq",    BRANCH, 3'b000, 7'h7F, 32'd9,        32'd9,        32'hFFFF_FFF8, 32'h100,     32'h0,        1, 32'h0,         0, 32'h0,         0, 0, 0, 32'hF8};
        vecs[3]  = '{"jal2",   JAL,    3'b000, 7'h00, 32'd0,        32'd0,        32'h8,         32'hF8,      32'h0,        1, 32'h100,       1, 32'hFC,        0, 0, 0, 32'h100};
        vecs[4]  = '{"bne",    BRANCH, 3'b001, 7'h7F, 32'd9,        32'd9,        32'hFFFF_FFF8, 32'h100,     32'h0,        1, 32'h0,         0, 32'h0,         0, 0, 0, 32'h104};
        vecs[5]  = '{"jalr",   JALR,   3'b000, 7'h00, 32'h201,      32'd0,        32'h2,         32'h40,      32'h0,        1, 32'h203,       1, 32'h44,        0, 0, 0, 32'h202};
        vecs[6]  = '{"illegal",FENCE,  3'b000, 7'h00, 32'd0,        32'd0,        32'h0,         32'h44,      32'h0,        0, 32'h0,         0, 32'h0,         0, 0, 1, 32'h206};
        vecs[7]  = '{"srai",   OPIMM,  3'b101, 7'h20, 32'h8000_0000,32'd0,        32'h404,       32'h206,     32'h0,        1, 32'hF800_0000, 1, 32'hF800_0000, 0, 0, 0, 32'h20A};
        vecs[8]  = '{"sub",    OPREG,  3'b000, 7'h20, 32'd3,        32'd5,        32'h0,         32'h20A,     32'h0,        1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 0, 0, 0, 32'h20E};
        vecs[9]  = '{"slt",    OPREG,  3'b010, 7'h00, 32'hFFFF_FFFF,32'd1,        32'h0,         32'h20E,     32'h0,        1, 32'h1,         1, 32'h1,         0, 0, 0, 32'h212};
        vecs[10] = '{"sltu",   OPREG,  3'b011, 7'h00, 32'hFFFF_FFFF,32'd1,        32'h0,         32'h212,     32'h0,        1, 32'h0,         1, 32'h0,         0, 0, 0, 32'h216};
        vecs[11] = '{"lui",    LUI,    3'b000, 7'h00, 32'h55,       32'd0,        32'h1234_5000, 32'h216,     32'h0,        1, 32'h1234_5000, 1, 32'h1234_5000, 0, 0, 0, 32'h21A};
        vecs[12] = '{"auipc",  AUIPC,  3'b000, 7'h00, 32'h55,       32'd0,        32'h2000,      32'h1000,    32'h0,        1, 32'h3000,      1, 32'h3000,      0, 0, 0, 32'h21E};
        vecs[13] = '{"bge",    BRANCH, 3'b101, 7'h00, 32'd5,        32'hFFFF_FFFD,32'h10,        32'h21E,     32'h0,        1, 32'h0,         0, 32'h0,         0, 0, 0, 32'h22E};
        vecs[14] = '{"bltu",   BRANCH, 3'b110, 7'h00, 32'd5,        32'hFFFF_FFFD,32'h10,        32'h22E,     32'h0,        1, 32'h1,         0, 32'h0,         0, 0, 0, 32'h23E};
        vecs[15] = '{"blt",    BRANCH, 3'b100, 7'h00, 32'd5,        32'hFFFF_FFFD,32'h10,        32'h23E,     32'h0,        1, 32'h0,         0, 32'h0,         0, 0, 0, 32'h242};
        vecs[16] = '{"sw",     STORE,  3'b010, 7'h00, 32'h100,      32'h77,       32'h8,         32'h242,     32'h0,        1, 32'h108,       0, 32'h0,         0, 1, 0, 32'h246};
        vecs[17] = '{"xori",   OPIMM,  3'b100, 7'h00, 32'hF0F0,     32'd0,        32'h0FF0,      32'h246,     32'h0,        1, 32'hFF00,      1, 32'hFF00,      0, 0, 0, 32'h24A};
        vecs[18] = '{"or",     OPREG,  3'b110, 7'h00, 32'hF0,       32'h0F,       32'h0,         32'h24A,     32'h0,        1, 32'hFF,        1, 32'hFF,        0, 0, 0, 32'h24E};
        vecs[19] = '{"andi",   OPIMM,  3'b111, 7'h00, 32'hFF,       32'd0,        32'h0F,        32'h24E,     32'h0,        1, 32'h0F,        1, 32'h0F,        0, 0, 0, 32'h252};
        vecs[20] = '{"slli",   OPIMM,  3'b001, 7'h00, 32'h1,        32'd0,        32'h1F,        32'h252,     32'h0,        1, 32'h8000_0000, 1, 32'h8000_0000, 0, 0, 0, 32'h256};
        vecs[21] = '{"srl",    OPREG,  3'b101, 7'h00, 32'h8000_0000,32'd4,        32'h0,         32'h256,     32'h0,        1, 32'h0800_0000, 1, 32'h0800_0000, 0, 0, 0, 32'h25A};
        vecs[22] = '{"jal_top",JAL,    3'b000, 7'h00, 32'd0,        32'd0,        32'hFFFF_FFFC, 32'h0,       32'h0,        1, 32'hFFFF_FFFC, 1, 32'h4,         0, 0, 0, 32'hFFFF_FFFC};
        vecs[23] = '{"wrap",   OPIMM,  3'b000, 7'h00, 32'd0,        32'd0,        32'h0,         32'hFFFF_FFFC,32'h0,       1, 32'h0,         1, 32'h0,         0, 0, 0, 32'h0};
        vecs[24] = '{"lw",     LOAD,   3'b010, 7'h00, 32'h10,       32'd0,        32'h4,         32'h0,       32'hDEAD_BEEF,1, 32'h14,        1, 32'hDEAD_BEEF, 1, 0, 0, 32'h4};

        // Reset: an unsupported opcode on the bus must not show while in FETCH.
        rst = 1'b0;
        bus.stall = 1'b0;
        apply(vecs[6]);
        step();
        step();
        chk("rst.next_pc", bus.next_pc, 32'h0);
        chk("rst.fetch", 32'(bus.fetch_next_instruction), 32'd1);
        chk("rst.load_ir", 32'(bus.load_ir), 32'd1);
        chk("rst.rd_we", 32'(bus.rd_we), 32'd0);
        chk("rst.dbus_re", 32'(bus.dbus_re), 32'd0);
        chk("rst.dbus_we", 32'(bus.dbus_we), 32'd0);
        chk("rst.illegal", 32'(bus.illegal), 32'd0);
        chk("rst.wb_stage", 32'(bus.write_back_stage), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) run_vec(vecs[i]);

        // Load held in EXECUTE by stall for three extra cycles (next_pc = 4).
        begin
            vec_t lw;
            lw = '{"lw_stall", LOAD, 3'b010, 7'h00, 32'h20, 32'd0, 32'h0, 32'h4,
                   32'hCAFE_F00D, 1, 32'h20, 1, 32'hCAFE_F00D, 1, 0, 0, 32'h8};
            apply(lw);
            bus.stall = 1'b0;
            step();
            bus.stall = 1'b1;
            for (int c = 0; c < 4; c++) begin
                #1;
                chk($sformatf("lw_stall.re%0d", c), 32'(bus.dbus_re), 32'd1);
                chk($sformatf("lw_stall.rdwe%0d", c), 32'(bus.rd_we), 32'd0);
                chk($sformatf("lw_stall.wb%0d", c), 32'(bus.write_back_stage), 32'd0);
                if (c == 3) bus.stall = 1'b0;
                step();
            end
            chk("lw_stall.wb_stage", 32'(bus.write_back_stage), 32'd1);
            chk("lw_stall.wb_re", 32'(bus.dbus_re), 32'd0);
            chk("lw_stall.rd_we", 32'(bus.rd_we), 32'd1);
            chk("lw_stall.rd_data", bus.rd_data, 32'hCAFE_F00D);
            step();
            chk("lw_stall.next_pc", bus.next_pc, 32'h8);
        end

        // Stall in FETCH, then stall in WRITEBACK: rd_we only on the exit cycle.
        begin
            vec_t ad;
            ad = '{"addi_stall", OPIMM, 3'b000, 7'h00, 32'd1, 32'd0, 32'h1, 32'h8,
                   32'h0, 1, 32'h2, 1, 32'h2, 0, 0, 0, 32'hC};
            apply(ad);
            bus.stall = 1'b1;
            step();
            chk("fstall.fetch", 32'(bus.fetch_next_instruction), 32'd1);
            chk("fstall.next_pc", bus.next_pc, 32'h8);
            bus.stall = 1'b0;
            step();
            chk("fstall.alu", bus.alu_out, 32'h2);
            step();
            bus.stall = 1'b1;
            #1;
            chk("wbstall.stage0", 32'(bus.write_back_stage), 32'd1);
            chk("wbstall.rdwe0", 32'(bus.rd_we), 32'd0);
            step();
            chk("wbstall.stage1", 32'(bus.write_back_stage), 32'd1);
            chk("wbstall.rdwe1", 32'(bus.rd_we), 32'd0);
            chk("wbstall.next_pc_hold", bus.next_pc, 32'h8);
            bus.stall = 1'b0;
            #1;
            chk("wbstall.rdwe_exit", 32'(bus.rd_we), 32'd1);
            chk("wbstall.rd_data", bus.rd_data, 32'h2);
            step();
            chk("wbstall.rdwe_after", 32'(bus.rd_we), 32'd0);
            chk("wbstall.next_pc", bus.next_pc, 32'hC);
        end

        // Reset asserted in WRITEBACK aborts the jump: no write, no PC load.
        begin
            vec_t jl;
            jl = '{"jal_abort", JAL, 3'b000, 7'h00, 32'd0, 32'd0, 32'h500, 32'h10,
                   32'h0, 1, 32'h510, 1, 32'h14, 0, 0, 0, 32'h510};
            apply(jl);
            bus.stall = 1'b0;
            step();
            step();
            chk("abort.rd_we_before", 32'(bus.rd_we), 32'd1);
            rst = 1'b0;
            #1;
            chk("abort.next_pc", bus.next_pc, 32'h0);
            chk("abort.rd_we", 32'(bus.rd_we), 32'd0);
            chk("abort.fetch", 32'(bus.fetch_next_instruction), 32'd1);
            chk("abort.wb_stage", 32'(bus.write_back_stage), 32'd0);
            step();
            chk("abort.next_pc_held", bus.next_pc, 32'h0);
            rst = 1'b1;
            jl = '{"after_abort", OPIMM, 3'b000, 7'h00, 32'd0, 32'd0, 32'h7, 32'h0,
                   32'h0, 1, 32'h7, 1, 32'h7, 0, 0, 0, 32'h4};
            run_vec(jl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_exec_control.md
# riscv_exec_control

Execution-control core of the multi-cycle RV32I CPU. It combines three parts: the control FSM, the ALU with its operand muxes, and the program counter with branch stepping. It takes already-decoded instruction fields plus register, immediate and memory data, and produces ALU results, write-back data and enables, memory strobes, fetch control and the next PC. It sits between the decoder/register file and the instruction/data memory units.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk in 1: clock, rising edge.
- rst in 1: reset, asynchronous, active-low.
- stall in 1: instruction or data bus not ready.
- opcode in 7: instruction opcode field.
- f3 in 3: funct3 field.
- f7 in 7: funct7 field.
- rs1_data in 32: register source 1 value.
- rs2_data in 32: register source 2 value.
- imm in 32: sign-extended immediate.
- insn_len in 32: instruction length in bytes (4).
- current_pc in 32: address of the executing instruction.
- mem_rdata in 32: load data from the memory unit.
- alu_out out 32: ALU result, also the data address.
- rd_data out 32: write-back value.
- rd_we out 1: register write strobe.
- dbus_re out 1: data read strobe.
- dbus_we out 1: data write strobe.
- fetch_next_instruction out 1: request an instruction fetch.
- load_ir out 1: capture the fetched instruction.
- write_back_stage out 1: FSM is in the WRITEBACK state.
- next_pc out 32: PC counter output.
- illegal out 1: opcode is unsupported.

## Operation
- Operand A mux selects one of: rs1_data, current_pc, or zero.
- Operand B mux selects one of: rs2_data or imm.
- ALU modes:
  - ADD and SUB wrap modulo 2^32.
  - SLL, SRL and SRA use shift amount b[4:0].
  - SLT is signed; SLTU is unsigned. Both return 1 or 0.
  - XOR, OR and AND are bitwise.
- Opcode decoding:
  - LUI 0110111: A=0, B=imm, ADD, rd from ALU.
  - AUIPC 0010111: A=PC, B=imm, ADD, rd from ALU.
  - JAL 1101111: A=PC, B=imm, ADD. PC is loaded with the ALU result. rd gets the link value.
  - JALR 1100111: A=rs1, B=imm, ADD. PC is loaded with alu_out with bit 0 cleared. rd gets the link value.
  - The link value is current_pc + insn_len.
  - BRANCH 1100011: A=rs1, B=rs2, no rd write. Mode and invert per f3:
    - BEQ: SUB with invert.
    - BNE: SUB.
    - BLT: SLT.
    - BGE: SLT with invert.
    - BLTU: SLTU.
    - BGEU: SLTU with invert.
  - LOAD 0000011: rs1+imm, dbus_re asserted, rd gets mem_rdata.
  - STORE 0100011: rs1+imm, dbus_we asserted, no rd write.
  - OP-IMM 0010011: A=rs1, B=imm, mode from f3. f3=101 with f7[5]=1 selects SRA.
  - OP 0110011: A=rs1, B=rs2, mode from f3. f7[5]=1 selects SUB when f3=000 and SRA when f3=101.
  - Any other opcode executes as a NOP: no rd write, PC advances by insn_len, illegal=1.
- Branch decision: take = (alu_out != 0) XOR invert.
- Step value: imm when the instruction is a branch and take=1; otherwise insn_len.
- PC counter:
  - load has priority over increment.
  - Increment adds the step value modulo 2^32.

## Timing
- FSM states: FETCH → EXECUTE → WRITEBACK → FETCH. Reset state is FETCH.
- FETCH:
  - fetch_next_instruction=1 and load_ir=1.
  - Stays in FETCH while stall=1; moves to EXECUTE on the first cycle with stall=0.
- EXECUTE:
  - ALU is combinational.
  - dbus_re and dbus_we are asserted for the whole EXECUTE state on loads and stores.
  - Non-memory instructions leave after 1 cycle.
  - Memory instructions stay while stall=1.
- WRITEBACK:
  - write_back_stage=1.
  - The state holds while stall=1.
  - rd_we is asserted only in the exiting cycle (stall=0) and only when the rd source is not NONE.
  - The PC load/increment takes effect on the same edge as the exit.
- Minimum latency is 3 cycles per instruction.
- Reset values:
  - next_pc=RESET_PC.
  - rd_we, dbus_re, dbus_we and illegal are 0.
  - fetch_next_instruction=1 and load_ir=1 (FETCH state).
- Asserting rst mid-instruction aborts it immediately. No register write or PC update occurs.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.

## Configuration
- EXEC_TRACE_EN:
  - Defined: on every state transition, $display prints the time, state, opcode, ALU mode, alu_out and next_pc.
  - Undefined: no trace output. Functional behaviour is identical either way.

## Test plan
- Reset with RESET_PC=0 → next_pc=0, state FETCH. Then stall=0 for 3 cycles → back in FETCH.
- ADDI with rs1=5, imm=-7 → alu_out=32'hFFFF_FFFE; rd_we is high for exactly 1 cycle in WRITEBACK; next_pc +4.
- BEQ with rs1=rs2=9, imm=-8, current_pc=0x100, next_pc=0x100 → next_pc=0xF8. Same stimulus with BNE → next_pc=0x104.
- JALR with rs1=0x201, imm=2, current_pc=0x40 → rd_data=0x44, next_pc=0x202.
- LW with stall held high for 3 EXECUTE cycles → dbus_re is high all 4 cycles, rd_we stays low until WRITEBACK, rd_data=mem_rdata.
- Opcode 0001111 → illegal=1, rd_we=0, next_pc +4. SRAI with 0x8000_0000, shift 4 → 0xF800_0000.
